// File: rtl/snake_body_queue.sv
// Snake segment list kept as a circular coordinate buffer; drives the snake_map step
// interface and decides game over from wall and self-hit checks.
//
// state | meaning
// IDLE  | waiting for start, body holds the single start cell
// RUN   | stepping on every tick
// DEAD  | collision seen; waiting for start to reinitialise
module snake_body_queue #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 6,
  parameter int XW      = 3,
  parameter int YW      = 3,
  parameter int MAX_LEN = 16,
  parameter int LW      = 5,
  parameter int START_X = 2,
  parameter int START_Y = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic             eat,
  input  logic             dir_valid,
  input  logic [1:0]       dir_in,
  input  logic             self_hit_now,
  output logic             map_tick,
  output logic             map_eat,
  output logic [XW+YW-1:0] head_xy,
  output logic [XW+YW-1:0] tail_xy,
  output logic [XW-1:0]    next_x,
  output logic [YW-1:0]    next_y,
  output logic             will_pop,
  output logic [LW-1:0]    length,
  output logic             running,
  output logic             game_over
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = XW + YW;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   body [MAX_LEN];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   len;
  logic [1:0]      dir, pending_dir, step_dir;
  logic            dir_ok, wall_hit, in_run, step_ok, collide, reinit;
  logic [XW:0]     hx_w, nx_w;
  logic [YW:0]     hy_w, ny_w;

  assign in_run = (state == RUN);
  // a 180-degree request is judged against the committed direction, not the pending one
  assign dir_ok   = dir_valid && (dir_in != (dir ^ 2'd2));
  assign step_dir = dir_ok ? dir_in : pending_dir;

  assign head_xy = body[wr_ptr - PW'(1)];
  assign tail_xy = body[rd_ptr];
  assign hx_w    = {1'b0, head_xy[CW-1:YW]};
  assign hy_w    = {1'b0, head_xy[YW-1:0]};

  always_comb begin
    nx_w = hx_w;
    ny_w = hy_w;
    case (step_dir)
      2'd0: ny_w = hy_w - (YW+1)'(1);
      2'd1: nx_w = hx_w + (XW+1)'(1);
      2'd2: ny_w = hy_w + (YW+1)'(1);
      default: nx_w = hx_w - (XW+1)'(1);
    endcase
  end

  // a step below zero wraps to a large unsigned value, so one compare covers both edges
  assign wall_hit = (nx_w >= (XW+1)'(GRID_W)) || (ny_w >= (YW+1)'(GRID_H));
  assign next_x   = nx_w[XW-1:0];
  assign next_y   = ny_w[YW-1:0];

  assign map_eat   = eat && (len < LW'(MAX_LEN));
  assign will_pop  = ~map_eat;
  assign map_tick  = tick && in_run && !wall_hit;
  assign step_ok   = map_tick && !self_hit_now;
  assign collide   = tick && in_run && (wall_hit || self_hit_now);
  assign reinit    = start && (state == DEAD);
  assign length    = len;
  assign running   = in_run;
  assign game_over = (state == DEAD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (collide) state_nxt = DEAD;
      DEAD:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || reinit) begin
      body[0]     <= {XW'(START_X), YW'(START_Y)};
      rd_ptr      <= '0;
      wr_ptr      <= PW'(1);
      len         <= LW'(1);
      dir         <= 2'd1;
      pending_dir <= 2'd1;
    end else begin
      if (dir_ok) pending_dir <= dir_in;
      if (step_ok) begin
        body[wr_ptr] <= {next_x, next_y};
        wr_ptr       <= wr_ptr + PW'(1);
        dir          <= step_dir;
        pending_dir  <= step_dir;
        if (will_pop) rd_ptr <= rd_ptr + PW'(1);
        else          len    <= len + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_snake_body_queue.sv
// Directed bench for snake_body_queue: vector table for the single-step behaviour,
// then a long grow-and-wrap run checked against a coordinate queue.
module tb_snake_body_queue;

  logic       clk = 1'b0;
  logic       reset, start, tick, eat, dir_valid, self_hit_now;
  logic [1:0] dir_in;
  logic       map_tick, map_eat, will_pop, running, game_over;
  logic [5:0] head_xy, tail_xy;
  logic [2:0] next_x, next_y;
  logic [4:0] length;

  int nchecks = 0;
  int nerr    = 0;

  snake_body_queue dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .eat(eat),
    .dir_valid(dir_valid), .dir_in(dir_in), .self_hit_now(self_hit_now),
    .map_tick(map_tick), .map_eat(map_eat), .head_xy(head_xy), .tail_xy(tail_xy),
    .next_x(next_x), .next_y(next_y), .will_pop(will_pop), .length(length),
    .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, tk, et, dv;
    logic [1:0] din;
    logic sh;
    logic mt;
    int   hx, hy, tx, ty, nx, ny;
    logic wp;
    int   len;
    logic run, over, cn;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic st, tk, et, dv, input logic [1:0] din, input logic sh,
                     input logic mt, input int hx, hy, tx, ty, nx, ny,
                     input logic wp, input int len, input logic run, over, cn);
    vec_t v;
    v.st = st; v.tk = tk; v.et = et; v.dv = dv; v.din = din; v.sh = sh;
    v.mt = mt; v.hx = hx; v.hy = hy; v.tx = tx; v.ty = ty; v.nx = nx; v.ny = ny;
    v.wp = wp; v.len = len; v.run = run; v.over = over; v.cn = cn;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, tk, et, dv, input logic [1:0] din, input logic sh);
    @(negedge clk);
    start = st; tick = tk; eat = et; dir_valid = dv; dir_in = din; self_hit_now = sh;
    #1;
  endtask

  task automatic chk_pos(input string tag, input int hx, hy, tx, ty, len);
    chk({tag, " head_x"}, int'(head_xy[5:3]), hx);
    chk({tag, " head_y"}, int'(head_xy[2:0]), hy);
    chk({tag, " tail_x"}, int'(tail_xy[5:3]), tx);
    chk({tag, " tail_y"}, int'(tail_xy[2:0]), ty);
    chk({tag, " length"}, int'(length), len);
  endtask

  initial begin
    int q_x[$], q_y[$];
    int hx, hy, nx, ny;
    logic [1:0] d;
    logic grow;
    string tag;

    reset = 1'b1; start = 0; tick = 0; eat = 0; dir_valid = 0; dir_in = 0; self_hit_now = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    //   st tk et dv din sh | mt hx hy tx ty nx ny wp len run over cn
    add(0, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0,   1, 2, 2, 2, 2, 3, 2, 0, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0,   1, 3, 2, 2, 2, 4, 2, 0, 2, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 4, 2, 2, 2, 5, 2, 1, 3, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 5, 2, 3, 2, 6, 2, 1, 3, 1, 0, 1);
    add(0, 0, 0, 1, 3, 0,   0, 5, 2, 3, 2, 6, 2, 1, 3, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 5, 2, 3, 2, 6, 2, 1, 3, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0,   0, 6, 2, 4, 2, 6, 1, 1, 3, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 6, 2, 4, 2, 6, 1, 1, 3, 1, 0, 1);
    add(0, 1, 0, 1, 2, 0,   1, 6, 1, 5, 2, 6, 0, 1, 3, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0,   1, 6, 0, 6, 2, 7, 0, 1, 3, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 7, 0, 6, 1, 0, 0, 1, 3, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 7, 0, 6, 1, 0, 0, 1, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 7, 0, 6, 1, 0, 0, 1, 3, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,   0, 7, 0, 6, 1, 0, 0, 1, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 2, 2, 2, 2, 3, 2, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,   0, 2, 2, 2, 2, 3, 2, 1, 1, 1, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].tk, vq[i].et, vq[i].dv, vq[i].din, vq[i].sh);
      tag = $sformatf("v%0d", i);
      chk({tag, " map_tick"}, int'(map_tick), int'(vq[i].mt));
      chk({tag, " map_eat"}, int'(map_eat), int'(!vq[i].wp));
      chk({tag, " will_pop"}, int'(will_pop), int'(vq[i].wp));
      chk({tag, " running"}, int'(running), int'(vq[i].run));
      chk({tag, " game_over"}, int'(game_over), int'(vq[i].over));
      chk_pos(tag, vq[i].hx, vq[i].hy, vq[i].tx, vq[i].ty, vq[i].len);
      if (vq[i].cn) begin
        chk({tag, " next_x"}, int'(next_x), vq[i].nx);
        chk({tag, " next_y"}, int'(next_y), vq[i].ny);
      end
    end

    // Circle a 2x2 square with eat held: fill to 16, then keep stepping so both pointers wrap.
    q_x = '{2}; q_y = '{2};
    for (int s = 0; s < 47; s++) begin
      case (s % 4)
        0: d = 2'd1;
        1: d = 2'd2;
        2: d = 2'd3;
        default: d = 2'd0;
      endcase
      hx = q_x[$]; hy = q_y[$];
      nx = hx + ((d == 2'd1) ? 1 : 0) - ((d == 2'd3) ? 1 : 0);
      ny = hy + ((d == 2'd2) ? 1 : 0) - ((d == 2'd0) ? 1 : 0);
      grow = (q_x.size() < 16);
      drive(0, 1, 1, 1, d, 0);
      tag = $sformatf("w%0d", s);
      chk({tag, " map_tick"}, int'(map_tick), 1);
      chk({tag, " map_eat"}, int'(map_eat), int'(grow));
      chk({tag, " will_pop"}, int'(will_pop), int'(!grow));
      chk({tag, " next_x"}, int'(next_x), nx);
      chk({tag, " next_y"}, int'(next_y), ny);
      chk_pos(tag, hx, hy, q_x[0], q_y[0], q_x.size());
      q_x.push_back(nx); q_y.push_back(ny);
      if (!grow) begin
        void'(q_x.pop_front());
        void'(q_y.pop_front());
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk_pos("wrap end", q_x[$], q_y[$], q_x[0], q_y[0], 16);
    chk("wrap end running", int'(running), 1);

    // Reset in the middle of a run wins over a simultaneous tick.
    @(negedge clk);
    reset = 1'b1; tick = 1'b1; eat = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_pos("mid reset", 2, 2, 2, 2, 1);
    chk("mid reset running", int'(running), 0);
    chk("mid reset game_over", int'(game_over), 0);
    chk("mid reset map_tick", int'(map_tick), 0);
    chk("mid reset next_x", int'(next_x), 3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
